// File: rtl/pwm_audio_capture.sv
// PWM audio capture: measures the high time of each PWM frame and queues it as a sample.
// Build option: define PWM_CAP_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module pwm_audio_capture #(
  parameter int PWM_PERIOD = 256,
  parameter int SAMPLE_W   = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                pwm_in,
  input  logic                enable,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                overflow,
  input  logic                clr_ovf,
  output logic                busy
);

  localparam int FW = $clog2(PWM_PERIOD);
  localparam int CW = FW + 1;
  localparam int MW = (CW > SAMPLE_W) ? CW : SAMPLE_W;
  localparam logic [FW-1:0] LAST = FW'(PWM_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [CW-1:0] cnt);
    logic [MW-1:0] ext;
    logic [MW-1:0] lim;
    ext = MW'(cnt);
    lim = MW'({SAMPLE_W{1'b1}});
    sat_sample = (ext > lim) ? lim[SAMPLE_W-1:0] : ext[SAMPLE_W-1:0];
  endfunction

  logic                sync1_q, pwm_s_q, pwm_prev_q;
  state_t              state_q, state_d;
  logic [FW-1:0]       frm_q, frm_d;
  logic [CW-1:0]       hi_q, hi_d;
  logic                push_q, push_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                rise;
  logic                pop;
  logic                full;
  logic                accept;
  logic                overflow_q;

  assign rise = pwm_s_q & ~pwm_prev_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1_q    <= 1'b0;
      pwm_s_q    <= 1'b0;
      pwm_prev_q <= 1'b0;
      state_q    <= IDLE;
      frm_q      <= '0;
      hi_q       <= '0;
      push_q     <= 1'b0;
      sample_q   <= '0;
    end else begin
      sync1_q    <= pwm_in;
      pwm_s_q    <= sync1_q;
      pwm_prev_q <= pwm_s_q;
      state_q    <= state_d;
      frm_q      <= frm_d;
      hi_q       <= hi_d;
      push_q     <= push_d;
      sample_q   <= sample_d;
    end
  end

  // The arming edge is frame cycle 0 and already counts as high, so RUN starts at cycle 1.
  always_comb begin
    state_d  = state_q;
    frm_d    = frm_q;
    hi_d     = hi_q;
    push_d   = 1'b0;
    sample_d = sample_q;
    case (state_q)
      IDLE: begin
        frm_d = '0;
        hi_d  = '0;
        if (enable) state_d = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = RUN;
          frm_d   = FW'(1);
          hi_d    = CW'(1);
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          frm_d   = '0;
          hi_d    = '0;
        end else if (frm_q == LAST) begin
          push_d   = 1'b1;
          sample_d = sat_sample(hi_q + CW'(pwm_s_q));
          frm_d    = '0;
          hi_d     = '0;
        end else begin
          frm_d = frm_q + FW'(1);
          hi_d  = hi_q + CW'(pwm_s_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign pop    = out_valid & out_ready;
  assign accept = push_q & (~full | pop);

`ifdef PWM_CAP_FIFO_EN
  logic [SAMPLE_W-1:0] mem_q [4];
  logic [1:0]          wr_q, rd_q;
  logic [2:0]          cnt_q;

  assign full      = (cnt_q == 3'd4);
  assign out_valid = (cnt_q != 3'd0);
  assign out_data  = out_valid ? mem_q[rd_q] : '0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) wr_q <= wr_q + 2'd1;
      if (pop)    rd_q <= rd_q + 2'd1;
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) mem_q[wr_q] <= sample_q;
  end
`else
  logic [SAMPLE_W-1:0] hold_q;
  logic                valid_q;

  assign full      = valid_q;
  assign out_valid = valid_q;
  assign out_data  = valid_q ? hold_q : '0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) hold_q <= sample_q;
  end
`endif

  // A fresh drop outranks a coincident clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      overflow_q <= 1'b0;
    end else if (push_q && full && !pop) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;

endmodule
